// File: rtl/artemis_ddr3_burst_ctrl.sv
// artemis_ddr3_burst_ctrl: drives one MCB user port. It splits a user burst into
// commands of up to MAX_BL words and moves the data between the user stream and the
// MCB write/read FIFOs. It reports done/error to the Wishbone slave above it.
module artemis_ddr3_burst_ctrl #(
    parameter int unsigned MAX_BL  = 64,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        calibration_done,
    input  logic        req_write,
    input  logic        req_read,
    input  logic [29:0] req_addr,
    input  logic [23:0] req_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [31:0] wr_data_in,
    input  logic        wr_strb,
    output logic        wr_ready,
    output logic [31:0] rd_data_out,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic        cmd_full,
    output logic        wr_en,
    output logic [3:0]  wr_mask,
    output logic [31:0] wr_data,
    input  logic        wr_full,
    input  logic        wr_underrun,
    input  logic        wr_error,
    output logic        rd_en,
    input  logic [31:0] rd_data,
    input  logic        rd_empty,
    input  logic        rd_overflow,
    input  logic        rd_error
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DRAIN, FINISH} state_t;

    state_t        state, state_nx;
    logic [29:0]   addr_q, addr_nx;
    logic [23:0]   rem_q, rem_nx;
    logic [6:0]    chunk_q, chunk_nx;
    logic [6:0]    xfer_q, xfer_nx;
    logic [TW-1:0] idle_q, idle_nx;
    logic          err_q, err_nx;
    logic [23:0]   rem_after;
    logic          fault;
    logic          push;
    logic          pop;

    // Words carried by the next command: the remainder, capped at MAX_BL.
    function automatic logic [6:0] chunk_of(input logic [23:0] words);
        return (words > 24'(MAX_BL)) ? 7'(MAX_BL) : words[6:0];
    endfunction

    assign rem_after = rem_q - 24'(chunk_q);
    assign fault     = wr_underrun | wr_error | rd_overflow | rd_error;
    assign error     = err_q;

    // State, address, word counters and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            chunk_q <= '0;
            xfer_q  <= '0;
            idle_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            addr_q  <= addr_nx;
            rem_q   <= rem_nx;
            chunk_q <= chunk_nx;
            xfer_q  <= xfer_nx;
            idle_q  <= idle_nx;
            err_q   <= err_nx;
        end
    end

    // Next-state logic and all port outputs.
    always_comb begin
        state_nx      = state;
        addr_nx       = addr_q;
        rem_nx        = rem_q;
        chunk_nx      = chunk_q;
        xfer_nx       = xfer_q;
        idle_nx       = idle_q;
        err_nx        = err_q | fault;
        push          = 1'b0;
        pop           = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        wr_ready      = 1'b0;
        wr_en         = 1'b0;
        wr_mask       = '0;
        wr_data       = '0;
        rd_valid      = 1'b0;
        rd_en         = 1'b0;
        rd_data_out   = '0;
        cmd_en        = 1'b0;
        cmd_instr     = '0;
        cmd_bl        = '0;
        cmd_byte_addr = '0;
        case (state)
            IDLE: begin
                if (calibration_done && (req_write || req_read)) begin
                    addr_nx  = {req_addr[29:2], 2'b00};
                    rem_nx   = req_count;
                    chunk_nx = chunk_of(req_count);
                    xfer_nx  = '0;
                    idle_nx  = '0;
                    err_nx   = fault;
                    if (req_count == '0)
                        state_nx = FINISH;
                    else if (req_write)
                        state_nx = WR_FILL;
                    else
                        state_nx = RD_CMD;
                end
            end
            WR_FILL: begin
                busy     = 1'b1;
                wr_ready = !wr_full;
                push     = wr_strb && !wr_full;
                wr_en    = push;
                wr_data  = wr_data_in;
                if (push) begin
                    if (xfer_q + 7'd1 == chunk_q) begin
                        xfer_nx  = '0;
                        state_nx = WR_CMD;
                    end else begin
                        xfer_nx = xfer_q + 7'd1;
                    end
                end
            end
            WR_CMD, RD_CMD: begin
                busy          = 1'b1;
                cmd_instr     = (state == RD_CMD) ? 3'b001 : 3'b000;
                cmd_bl        = 6'(chunk_q - 7'd1);
                cmd_byte_addr = addr_q;
                if (!cmd_full) begin
                    cmd_en  = 1'b1;
                    addr_nx = addr_q + 30'({chunk_q, 2'b00});
                    rem_nx  = rem_after;
                    if (state == RD_CMD) begin
                        // The chunk register keeps this command's length for the drain phase.
                        state_nx = RD_DRAIN;
                        xfer_nx  = '0;
                        idle_nx  = '0;
                    end else if (rem_after != '0) begin
                        state_nx = WR_FILL;
                        chunk_nx = chunk_of(rem_after);
                    end else begin
                        state_nx = FINISH;
                    end
                end
            end
            RD_DRAIN: begin
                busy        = 1'b1;
                rd_valid    = !rd_empty;
                rd_data_out = rd_data;
                pop         = !rd_empty && rd_ready;
                rd_en       = pop;
                if (pop) begin
                    idle_nx = '0;
                    if (xfer_q + 7'd1 == chunk_q) begin
                        xfer_nx = '0;
                        if (rem_q != '0) begin
                            state_nx = RD_CMD;
                            chunk_nx = chunk_of(rem_q);
                        end else begin
                            state_nx = FINISH;
                        end
                    end else begin
                        xfer_nx = xfer_q + 7'd1;
                    end
                end else if (rd_empty) begin
                    if (idle_q == TW'(TIMEOUT - 1)) begin
                        err_nx   = 1'b1;
                        state_nx = FINISH;
                    end else begin
                        idle_nx = idle_q + 1'b1;
                    end
                end else begin
                    idle_nx = '0;
                end
            end
            FINISH: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_artemis_ddr3_burst_ctrl.sv
// Bench for artemis_ddr3_burst_ctrl: MCB FIFO model, request table, hand-written
// corner sequences and randomized requests checked against a chunking model.
module tb_artemis_ddr3_burst_ctrl;

    localparam int unsigned MAX_BL  = 64;
    localparam int unsigned TIMEOUT = 50;

    typedef logic [38:0] cmd_t;   // {instr, bl, byte_addr}

    typedef struct {
        bit          wr;
        logic [29:0] addr;
        int unsigned count;
        int unsigned exp_ncmd;
        logic [29:0] f_addr;
        logic [5:0]  f_bl;
        logic [29:0] l_addr;
        logic [5:0]  l_bl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, calibration_done, req_write, req_read;
    logic [29:0] req_addr;
    logic [23:0] req_count;
    logic        busy, done, error;
    logic [31:0] wr_data_in;
    logic        wr_strb, wr_ready;
    logic [31:0] rd_data_out;
    logic        rd_valid, rd_ready;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_full;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        wr_full, wr_underrun, wr_error;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_empty, rd_overflow, rd_error;

    always #5 clk = ~clk;

    artemis_ddr3_burst_ctrl #(.MAX_BL(MAX_BL), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .calibration_done(calibration_done),
        .req_write(req_write), .req_read(req_read), .req_addr(req_addr), .req_count(req_count),
        .busy(busy), .done(done), .error(error),
        .wr_data_in(wr_data_in), .wr_strb(wr_strb), .wr_ready(wr_ready),
        .rd_data_out(rd_data_out), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
        .cmd_full(cmd_full),
        .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
        .wr_full(wr_full), .wr_underrun(wr_underrun), .wr_error(wr_error),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
        .rd_overflow(rd_overflow), .rd_error(rd_error)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    cmd_t        cmd_log[$], exp_cmd[$];
    logic [31:0] wr_src[$], exp_wr[$], wr_log[$], rd_q[$], exp_rd[$], rd_log[$];
    int unsigned cyc = 0, cmd_cyc = 0, done_cyc = 0, done_cnt = 0;
    bit          done_err, mask_bad, busy_seen, seen_wr_ready, seen_wr_en, seen_cmd_en;

    int unsigned strb_pct, full_pct, cmdfull_pct, ready_pct, empty_pct;
    bit          noise_en, toggle_ready, force_wr_full, force_cmd_full, force_rd_empty;

    vec_t        tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_q(input string name, input logic [31:0] act[$], input logic [31:0] exp[$]);
        bit bad = 0;
        vectors++;
        if (act.size() != exp.size()) begin
            miscompares++;
            $display("FAIL %s: got %0d words, expected %0d words", name, act.size(), exp.size());
        end else begin
            for (int unsigned i = 0; i < act.size(); i++) begin
                if (!bad && act[i] !== exp[i]) begin
                    bad = 1;
                    miscompares++;
                    $display("FAIL %s: word %0d got 0x%0h, expected 0x%0h", name, i, act[i], exp[i]);
                end
            end
        end
    endtask

    task automatic check_cmds(input string name);
        bit bad = 0;
        vectors++;
        if (cmd_log.size() != exp_cmd.size()) begin
            miscompares++;
            $display("FAIL %s: got %0d commands, expected %0d", name, cmd_log.size(), exp_cmd.size());
        end else begin
            for (int unsigned i = 0; i < cmd_log.size(); i++) begin
                if (!bad && cmd_log[i] !== exp_cmd[i]) begin
                    bad = 1;
                    miscompares++;
                    $display("FAIL %s: cmd %0d got 0x%0h, expected 0x%0h", name, i, cmd_log[i], exp_cmd[i]);
                end
            end
        end
    endtask

    function automatic cmd_t cmd_at(input int unsigned i);
        return (i < cmd_log.size()) ? cmd_log[i] : '0;
    endfunction

    // Reference: split count words into MAX_BL pieces at word offsets from the aligned base.
    function automatic void model_cmds(input bit wr, input logic [29:0] a, input int unsigned n);
        int unsigned base, off, c;
        exp_cmd.delete();
        base = 32'(a) & ~32'd3;
        off  = 0;
        while (off < n) begin
            c = (n - off > MAX_BL) ? MAX_BL : n - off;
            exp_cmd.push_back({wr ? 3'b000 : 3'b001, 6'(c - 1), 30'(base + off * 4)});
            off += c;
        end
    endfunction

    function automatic bit outs_zero();
        return !(busy || done || error || wr_ready || rd_valid || cmd_en || wr_en || rd_en) &&
               cmd_instr == 3'd0 && cmd_bl == 6'd0 && cmd_byte_addr == 30'd0 &&
               wr_mask == 4'd0 && wr_data == 32'd0 && rd_data_out == 32'd0;
    endfunction

    task automatic set_knobs(input int unsigned s, input int unsigned f, input int unsigned cf,
                             input int unsigned r, input int unsigned e, input bit nz);
        strb_pct = s; full_pct = f; cmdfull_pct = cf; ready_pct = r; empty_pct = e; noise_en = nz;
    endtask

    // One clock: drive inputs at the falling edge, sample the DUT 1ns later, then log events.
    task automatic cycle();
        logic [31:0] w;
        wr_full  = force_wr_full  || ($urandom_range(99) < full_pct);
        cmd_full = force_cmd_full || ($urandom_range(99) < cmdfull_pct);
        rd_ready = toggle_ready ? !rd_ready : ($urandom_range(99) < ready_pct);
        rd_empty = force_rd_empty || (rd_q.size() == 0) || ($urandom_range(99) < empty_pct);
        rd_data  = (rd_q.size() != 0) ? rd_q[0] : $urandom;
        if (wr_src.size() != 0 && $urandom_range(99) < strb_pct) begin
            wr_strb    = 1'b1;
            wr_data_in = wr_src[0];
        end else begin
            wr_strb    = 1'b0;
            wr_data_in = $urandom;
        end
        #1;
        seen_wr_ready = wr_ready;
        seen_wr_en    = wr_en;
        seen_cmd_en   = cmd_en;
        if (busy) busy_seen = 1;
        if (cmd_en) begin
            cmd_log.push_back({cmd_instr, cmd_bl, cmd_byte_addr});
            cmd_cyc = cyc;
            if (cmd_instr == 3'b001) begin
                for (int unsigned i = 0; i <= 32'(cmd_bl); i++) begin
                    w = $urandom;
                    rd_q.push_back(w);
                    exp_rd.push_back(w);
                end
            end
        end
        if (wr_en) begin
            wr_log.push_back(wr_data);
            if (wr_mask != 4'd0) mask_bad = 1;
        end
        if (wr_strb && wr_ready) void'(wr_src.pop_front());
        if (rd_en) begin
            rd_log.push_back(rd_data_out);
            if (rd_q.size() != 0) void'(rd_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = error;
        end
        if (noise_en && busy) begin
            req_write = 1'($urandom_range(1));
            req_read  = 1'($urandom_range(1));
            req_addr  = 30'($urandom);
            req_count = 24'($urandom);
        end
        cyc++;
        @(negedge clk);
        req_write = 1'b0;
        req_read  = 1'b0;
    endtask

    task automatic start_req(input bit wr, input logic [29:0] a, input logic [23:0] n);
        logic [31:0] w;
        cmd_log.delete(); wr_log.delete(); rd_log.delete(); exp_wr.delete();
        wr_src.delete(); exp_rd.delete(); rd_q.delete();
        done_cnt = 0; done_err = 0; mask_bad = 0; busy_seen = 0;
        if (wr) begin
            for (int unsigned i = 0; i < 32'(n); i++) begin
                w = $urandom;
                wr_src.push_back(w);
                exp_wr.push_back(w);
            end
        end
        req_write = wr;
        req_read  = !wr;
        req_addr  = a;
        req_count = n;
        cycle();
    endtask

    task automatic wait_done(input int unsigned budget, input string name);
        int unsigned k = 0;
        while (done_cnt == 0 && k < budget) begin
            cycle();
            k++;
        end
        if (done_cnt == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic wait_words(input int unsigned n);
        int unsigned k = 0;
        while (wr_log.size() < n && k < 500) begin
            cycle();
            k++;
        end
    endtask

    bit          r_wr, bad;
    logic [29:0] r_addr;
    int unsigned r_n, rel;
    vec_t        v;

    initial begin
        tbl[0] = '{1'b1, 30'h100,      100, 2, 30'h100,      6'd63, 30'h200, 6'd35};
        tbl[1] = '{1'b1, 30'h103,        1, 1, 30'h100,      6'd0,  30'h100, 6'd0};
        tbl[2] = '{1'b1, 30'h3FFFFF00, 128, 2, 30'h3FFFFF00, 6'd63, 30'h0,   6'd63};
        tbl[3] = '{1'b0, 30'h40,        64, 1, 30'h40,       6'd63, 30'h40,  6'd63};
        tbl[4] = '{1'b0, 30'h2,         65, 2, 30'h0,        6'd63, 30'h100, 6'd0};
        tbl[5] = '{1'b1, 30'h500,        0, 0, 30'h0,        6'd0,  30'h0,   6'd0};
        tbl[6] = '{1'b0, 30'h7FC,        0, 0, 30'h0,        6'd0,  30'h0,   6'd0};
        tbl[7] = '{1'b0, 30'h3FFFFFFC, 130, 3, 30'h3FFFFFFC, 6'd63, 30'h1FC, 6'd1};
        tbl[8] = '{1'b1, 30'h10,        65, 2, 30'h10,       6'd63, 30'h110, 6'd0};

        rst = 1; calibration_done = 1; req_write = 0; req_read = 0; req_addr = '0; req_count = '0;
        wr_data_in = '0; wr_strb = 0; rd_ready = 0; cmd_full = 0; wr_full = 0; wr_underrun = 0;
        wr_error = 0; rd_data = '0; rd_empty = 1; rd_overflow = 0; rd_error = 0;
        toggle_ready = 0; force_wr_full = 0; force_cmd_full = 0; force_rd_empty = 0;
        set_knobs(0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (3) cycle();
        check("reset_outputs_zero", outs_zero(), 1);
        rst = 0;
        cycle();
        check("idle_after_reset", outs_zero(), 1);

        // Request table under random backpressure, with ignored requests while busy
        set_knobs(70, 20, 30, 70, 30, 1);
        for (int unsigned t = 0; t < 9; t++) begin
            v = tbl[t];
            start_req(v.wr, v.addr, 24'(v.count));
            wait_done(40 * v.count + 300, $sformatf("tbl%0d", t));
            repeat (3) cycle();
            check($sformatf("tbl%0d_ncmd", t), cmd_log.size(), v.exp_ncmd);
            if (v.exp_ncmd != 0) begin
                check($sformatf("tbl%0d_first_cmd", t), cmd_at(0),
                      {v.wr ? 3'b000 : 3'b001, v.f_bl, v.f_addr});
                check($sformatf("tbl%0d_last_cmd", t), cmd_at(v.exp_ncmd - 1),
                      {v.wr ? 3'b000 : 3'b001, v.l_bl, v.l_addr});
            end
            if (v.wr) begin
                check_q($sformatf("tbl%0d_wr_data", t), wr_log, exp_wr);
                check($sformatf("tbl%0d_wr_mask", t), mask_bad, 0);
            end else begin
                check($sformatf("tbl%0d_rd_count", t), rd_log.size(), v.count);
                check_q($sformatf("tbl%0d_rd_data", t), rd_log, exp_rd);
            end
            check($sformatf("tbl%0d_done_count", t), done_cnt, 1);
            check($sformatf("tbl%0d_error", t), error, 0);
            check($sformatf("tbl%0d_busy_after", t), busy, 0);
        end

        // Read of 64 words with rd_ready toggling every cycle
        set_knobs(0, 0, 0, 0, 0, 0);
        toggle_ready = 1;
        start_req(1'b0, 30'h1000, 24'd64);
        wait_done(1000, "t2");
        repeat (2) cycle();
        toggle_ready = 0;
        check("t2_ncmd", cmd_log.size(), 1);
        check("t2_cmd", cmd_at(0), {3'b001, 6'd63, 30'h1000});
        check("t2_rd_count", rd_log.size(), 64);
        check_q("t2_rd_data", rd_log, exp_rd);
        check("t2_done_count", done_cnt, 1);
        check("t2_busy_after", busy, 0);

        // wr_full held for 10 cycles in the middle of a fill
        set_knobs(100, 0, 0, 0, 0, 0);
        start_req(1'b1, 30'h2000, 24'd100);
        wait_words(30);
        force_wr_full = 1;
        bad = 0;
        repeat (10) begin
            cycle();
            if (seen_wr_ready || seen_wr_en) bad = 1;
        end
        force_wr_full = 0;
        check("t3_stall_ready_or_push", bad, 0);
        wait_done(1000, "t3");
        check_q("t3_wr_data", wr_log, exp_wr);
        check("t3_ncmd", cmd_log.size(), 2);

        // cmd_full held for 5 cycles in WR_CMD
        force_cmd_full = 1;
        start_req(1'b1, 30'h80, 24'd4);
        wait_words(4);
        bad = 0;
        repeat (5) begin
            cycle();
            if (seen_cmd_en) bad = 1;
        end
        force_cmd_full = 0;
        rel = cyc;
        check("t4_no_cmd_while_full", bad, 0);
        wait_done(100, "t4");
        check("t4_ncmd", cmd_log.size(), 1);
        check("t4_cmd", cmd_at(0), {3'b000, 6'd3, 30'h80});
        check("t4_cmd_cycle", cmd_cyc, rel);

        // Read FIFO never delivers: abort after TIMEOUT idle cycles
        force_rd_empty = 1;
        start_req(1'b0, 30'h200, 24'd10);
        wait_done(300, "t5");
        check("t5_timeout_latency", done_cyc - cmd_cyc, TIMEOUT + 1);
        check("t5_error_at_done", done_err, 1);
        check("t5_rd_count", rd_log.size(), 0);
        force_rd_empty = 0;
        start_req(1'b1, 30'h300, 24'd1);
        check("t5_error_cleared", error, 0);
        wait_done(100, "t5b");

        // MCB fault flag mid-write: error set, transfer still completes
        start_req(1'b1, 30'h400, 24'd10);
        wait_words(3);
        rd_overflow = 1;
        cycle();
        rd_overflow = 0;
        wait_done(200, "fault");
        check("fault_error_at_done", done_err, 1);
        check_q("fault_wr_data", wr_log, exp_wr);

        // Reset in the middle of a write, then requests while not calibrated
        start_req(1'b1, 30'h600, 24'd100);
        wait_words(20);
        rst = 1;
        cycle();
        rst = 0;
        check("t6_outputs_zero", outs_zero(), 1);
        repeat (3) cycle();
        check("t6_no_done", done_cnt, 0);
        calibration_done = 0;
        start_req(1'b1, 30'h40, 24'd5);
        repeat (4) cycle();
        check("t6_uncal_busy", busy_seen, 0);
        check("t6_uncal_cmd", cmd_log.size(), 0);
        check("t6_uncal_wr", wr_log.size(), 0);
        calibration_done = 1;
        wr_src.delete();

        // Randomized requests against the chunking model
        set_knobs(60, 20, 30, 60, 30, 1);
        for (int unsigned r = 0; r < 40; r++) begin
            r_wr   = 1'($urandom_range(1));
            r_addr = 30'($urandom);
            r_n    = $urandom_range(160);
            model_cmds(r_wr, r_addr, r_n);
            start_req(r_wr, r_addr, 24'(r_n));
            wait_done(40 * r_n + 300, $sformatf("rnd%0d", r));
            repeat (2) cycle();
            check_cmds($sformatf("rnd%0d_cmds", r));
            if (r_wr) begin
                check_q($sformatf("rnd%0d_wr_data", r), wr_log, exp_wr);
            end else begin
                check($sformatf("rnd%0d_rd_count", r), rd_log.size(), r_n);
                check_q($sformatf("rnd%0d_rd_data", r), rd_log, exp_rd);
            end
            check($sformatf("rnd%0d_done_count", r), done_cnt, 1);
            check($sformatf("rnd%0d_error", r), error, 0);
            check($sformatf("rnd%0d_busy_after", r), busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
